// File: rtl/seq_multiplier_signed.sv
// Iterative shift-add multiplier with a per-operation signed/unsigned mode,
// optional early termination and a busy/done handshake.
// Operands are converted to sign + magnitude on acceptance. The magnitudes are
// multiplied by shift-add, one multiplier bit per cycle, and the sign is
// applied once at the end.
module seq_multiplier_signed #(
  parameter int unsigned WIDTH      = 4,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   res,
  output logic                 done,
  output logic                 busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mag_a_q;
  logic [WIDTH-1:0] mag_b_q;
  logic [PW-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q;
  logic [PW-1:0]    res_q;
  logic             done_q;
  logic             busy_q;

  logic [WIDTH-1:0] mag_a_d;
  logic [WIDTH-1:0] mag_b_ld_d;
  logic             neg_d;
  logic [PW-1:0]    acc_d;
  logic [WIDTH-1:0] mag_b_d;
  logic [CW-1:0]    cnt_d;
  logic             run_last_d;
  logic [PW-1:0]    res_d;

  // Operand conditioning on acceptance and the per-iteration datapath step
  always_comb begin
    mag_a_d    = (signed_mode & A[WIDTH-1]) ? (~A + 1'b1) : A;
    mag_b_ld_d = (signed_mode & B[WIDTH-1]) ? (~B + 1'b1) : B;
    neg_d      = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
    acc_d      = acc_q;
    if (mag_b_q[0]) begin
      acc_d = acc_q + ({{WIDTH{1'b0}}, mag_a_q} << cnt_q);
    end
    mag_b_d    = mag_b_q >> 1;
    cnt_d      = cnt_q + 1'b1;
    run_last_d = (cnt_d == CNT_LAST) || (EARLY_EXIT && (mag_b_d == '0));
    res_d      = neg_q ? (~acc_q + 1'b1) : acc_q;
  end

  // Control FSM and registered outputs. The result and done are written on
  // the FINISH edge, so the done cycle is spent in IDLE with busy still high;
  // that trailing IDLE cycle drops busy and refuses to accept a start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (start) begin
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_ld_d;
            neg_q   <= neg_d;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q   <= acc_d;
          mag_b_q <= mag_b_d;
          cnt_q   <= cnt_d;
          if (run_last_d) begin
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          res_q   <= res_d;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign res  = res_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_seq_multiplier_signed.sv
// Self-checking bench for seq_multiplier_signed: a WIDTH=4 instance with
// EARLY_EXIT=0 and a WIDTH=8 instance with EARLY_EXIT=1.
module tb_seq_multiplier_signed;

  logic        clk;
  logic        rst;
  logic        st4, sm4, done4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  res4;
  logic        st8, sm8, done8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;

  int checks   = 0;
  int failures = 0;

  seq_multiplier_signed #(.WIDTH(4), .EARLY_EXIT(1'b0)) dut4 (
    .clk(clk), .reset(rst), .start(st4), .signed_mode(sm4),
    .A(a4), .B(b4), .res(res4), .done(done4), .busy(busy4)
  );

  seq_multiplier_signed #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut8 (
    .clk(clk), .reset(rst), .start(st8), .signed_mode(sm8),
    .A(a8), .B(b8), .res(res8), .done(done8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int which, input logic st, input logic [7:0] a,
                        input logic [7:0] b, input logic sm);
    if (which == 0) begin
      st4 = st; a4 = a[3:0]; b4 = b[3:0]; sm4 = sm;
    end else begin
      st8 = st; a8 = a; b8 = b; sm8 = sm;
    end
  endtask

  function automatic logic [15:0] o_res(input int which);
    return (which == 0) ? {8'h00, res4} : res8;
  endfunction
  function automatic logic o_done(input int which);
    return (which == 0) ? done4 : done8;
  endfunction
  function automatic logic o_busy(input int which);
    return (which == 0) ? busy4 : busy8;
  endfunction

  // Reference: operand value as an integer under the chosen mode
  function automatic longint val(input int w, input logic [7:0] v, input logic sm);
    longint u;
    u = longint'(v) & ((longint'(1) << w) - 1);
    if (sm && (((u >> (w - 1)) & 1) == 1)) return u - (longint'(1) << w);
    return u;
  endfunction

  function automatic logic [15:0] ref_prod(input int w, input logic [7:0] a,
                                           input logic [7:0] b, input logic sm);
    longint p;
    p = val(w, a, sm) * val(w, b, sm);
    return 16'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic int ref_lat(input int w, input bit ee, input logic [7:0] b,
                                 input logic sm);
    longint m;
    int k;
    if (!ee) return w + 1;
    m = val(w, b, sm);
    if (m < 0) m = -m;
    k = 1;
    for (int i = 0; i < w; i++) if (((m >> i) & 1) == 1) k = i + 1;
    return k + 1;
  endfunction

  // One operation: start, optional re-poke while busy, optional start held
  // during the done cycle, then latency/result/pulse checks.
  task automatic run_op(input int which, input logic [7:0] a, input logic [7:0] b,
                        input logic sm, input int poke, input bit hold_done,
                        input string tag);
    int w, lat, cyc;
    bit got;
    logic [15:0] exp_res;
    w       = (which == 0) ? 4 : 8;
    exp_res = ref_prod(w, a, b, sm);
    lat     = ref_lat(w, which != 0, b, sm);
    @(negedge clk);
    set_in(which, 1'b1, a, b, sm);
    @(posedge clk);
    #1;
    set_in(which, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    check({tag, "_busy_first"}, 32'(o_busy(which)), 32'd1);
    cyc = 0;
    got = 0;
    while (!got && cyc < 40) begin
      if (cyc == poke) set_in(which, 1'b1, 8'hFF, 8'hFF, 1'b0);
      else set_in(which, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      @(posedge clk);
      #1;
      cyc++;
      if (o_done(which)) got = 1;
    end
    set_in(which, hold_done, 8'h01, 8'h01, 1'b0);
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    check({tag, "_res"}, 32'(o_res(which)), 32'(exp_res));
    check({tag, "_busy_done"}, 32'(o_busy(which)), 32'd1);
    @(posedge clk);
    #1;
    set_in(which, 1'b0, 8'h00, 8'h00, 1'b0);
    check({tag, "_done_pulse"}, 32'(o_done(which)), 32'd0);
    check({tag, "_busy_after"}, 32'(o_busy(which)), 32'd0);
  endtask

  int order [512];

  initial begin
    rst = 1'b1;
    set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
    set_in(1, 1'b0, 8'h00, 8'h00, 1'b0);
    #1;
    check("reset_res4", 32'(res4), 32'd0);
    check("reset_done4", 32'(done4), 32'd0);
    check("reset_busy4", 32'(busy4), 32'd0);
    check("reset_res8", 32'(res8), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed WIDTH=4 cases
    run_op(0, 8'd13, 8'd11, 1'b0, -1, 1'b0, "u13x11");
    run_op(0, 8'hD, 8'd5, 1'b1, -1, 1'b0, "sm3x5");
    run_op(0, 8'h8, 8'h8, 1'b1, -1, 1'b0, "sm8xm8");
    run_op(0, 8'h8, 8'h7, 1'b1, -1, 1'b0, "sm8x7");
    run_op(0, 8'h0, 8'hF, 1'b1, -1, 1'b0, "s0xm1");

    // Start while busy is ignored; start held through the done cycle too
    run_op(0, 8'd2, 8'd3, 1'b0, 2, 1'b1, "busy_poke");
    repeat (8) begin
      @(posedge clk);
      #1;
      check("no_second_done", 32'(done4), 32'd0);
    end
    check("res_held", 32'(res4), 32'h06);
    run_op(0, 8'd15, 8'd15, 1'b0, -1, 1'b0, "u15x15");

    // Asynchronous reset mid-operation
    @(negedge clk);
    set_in(0, 1'b1, 8'd13, 8'd11, 1'b0);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 8'd0, 8'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_res", 32'(res4), 32'd0);
    check("midrst_done", 32'(done4), 32'd0);
    check("midrst_busy", 32'(busy4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 8'd1, 8'd1, 1'b0, -1, 1'b0, "after_rst");

    // Early-exit WIDTH=8 cases
    run_op(1, 8'h05, 8'h01, 1'b0, -1, 1'b0, "ee_b1");
    run_op(1, 8'h5A, 8'h00, 1'b1, -1, 1'b0, "ee_b0");
    run_op(1, 8'hFF, 8'h80, 1'b0, -1, 1'b0, "ee_ff_x80");
    run_op(1, 8'h80, 8'h80, 1'b1, -1, 1'b0, "ee_sm128sq");
    run_op(1, 8'h13, 8'hFD, 1'b1, -1, 1'b0, "ee_s19xm3");
    for (int i = 0; i < 40; i++) begin
      run_op(1, 8'($urandom), 8'($urandom >> $urandom_range(0, 7)), 1'($urandom),
             -1, 1'b0, "ee_rand");
    end

    // Shuffled exhaustive sweep, WIDTH=4, both modes, back-to-back
    for (int i = 0; i < 512; i++) order[i] = i;
    for (int i = 511; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(0, i));
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(order[i]);
      run_op(0, {4'h0, v[3:0]}, {4'h0, v[7:4]}, v[8], -1, 1'b0, "sweep");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
